// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy level,
// programmable almost-full/almost-empty and sticky overflow/underflow flags.
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_afull,
    output logic                  wr_overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  rd_aempty,
    output logic                  rd_underflow,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;
    localparam int CAP   = DEPTH + ((FWFT != 0) ? 1 : 0);

    localparam logic [LW-1:0]         CAP_L    = LW'(CAP);
    localparam logic [LW-1:0]         LVL_ZERO = LW'(0);
    localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DAT_ZERO = DATA_WIDTH'(0);

    // Thresholds are signed ints so out-of-range values simply pin the flag.
    function automatic logic afull_f(input logic [LW-1:0] lvl);
        int v;
        v = {{(32-LW){1'b0}}, lvl};
        return (v >= AFULL_THRESH);
    endfunction

    function automatic logic aempty_f(input logic [LW-1:0] lvl);
        int v;
        v = {{(32-LW){1'b0}}, lvl};
        return (v <= AEMPTY_THRESH);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_wr_full;
    logic                  r_wr_afull;
    logic                  r_rd_empty;
    logic                  r_rd_aempty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [LW-1:0]         w_level_nxt;
    logic [LW-1:0]         w_ram_cnt;
    logic                  w_out_free;
    logic                  w_ram_rd;
    logic                  w_ram_wr;
    logic                  w_bypass;
    logic                  w_valid_nxt;
    logic                  w_empty_nxt;
    logic [DATA_WIDTH-1:0] w_ram_head;
    logic [DATA_WIDTH-1:0] w_data_nxt;

    // Accept decisions, next level and output-register steering from start-of-cycle state.
    always_comb begin
        w_wr_acc   = wr_en & ~r_wr_full;
        w_rd_acc   = rd_en & ~r_rd_empty;
        w_ram_head = r_mem[r_rd_ptr];

        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase

        if (FWFT != 0) begin
            // In FWFT the level includes the output register, so RAM holds the rest.
            w_ram_cnt   = r_level - {{(LW-1){1'b0}}, r_rd_valid};
            w_out_free  = ~r_rd_valid | w_rd_acc;
            w_ram_rd    = w_out_free & (w_ram_cnt != LVL_ZERO);
            w_bypass    = w_out_free & (w_ram_cnt == LVL_ZERO) & w_wr_acc;
            w_valid_nxt = w_ram_rd | w_bypass | (r_rd_valid & ~w_rd_acc);
            w_empty_nxt = ~w_valid_nxt;
        end else begin
            w_ram_cnt   = r_level;
            w_out_free  = w_rd_acc;
            w_ram_rd    = w_rd_acc;
            w_bypass    = 1'b0;
            w_valid_nxt = w_rd_acc;
            w_empty_nxt = (w_level_nxt == LVL_ZERO);
        end

        w_ram_wr = w_wr_acc & ~w_bypass;

        if (w_ram_rd) begin
            w_data_nxt = w_ram_head;
        end else if (w_bypass) begin
            w_data_nxt = wr_data;
        end else begin
            w_data_nxt = r_rd_data;
        end
    end

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, level, output register, registered flags and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= PTR_ZERO;
            r_rd_ptr    <= PTR_ZERO;
            r_level     <= LVL_ZERO;
            r_rd_data   <= DAT_ZERO;
            r_rd_valid  <= 1'b0;
            r_wr_full   <= 1'b0;
            r_wr_afull  <= afull_f(LVL_ZERO);
            r_rd_empty  <= 1'b1;
            r_rd_aempty <= aempty_f(LVL_ZERO);
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ram_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_level     <= w_level_nxt;
            r_rd_data   <= w_data_nxt;
            r_rd_valid  <= w_valid_nxt;
            r_wr_full   <= (w_level_nxt == CAP_L);
            r_wr_afull  <= afull_f(w_level_nxt);
            r_rd_empty  <= w_empty_nxt;
            r_rd_aempty <= aempty_f(w_level_nxt);
            // A new error event in the same cycle as clr_err keeps the flag set.
            r_overflow  <= (wr_en & r_wr_full)  | (r_overflow  & ~clr_err);
            r_underflow <= (rd_en & r_rd_empty) | (r_underflow & ~clr_err);
        end
    end

    assign wr_full      = r_wr_full;
    assign wr_afull     = r_wr_afull;
    assign wr_overflow  = r_overflow;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign rd_empty     = r_rd_empty;
    assign rd_aempty    = r_rd_aempty;
    assign rd_underflow = r_underflow;
    assign level        = r_level;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: a standard-mode and an FWFT instance (depth 4) share clock and reset;
// accepted writes are queued as expected read data, and a negedge monitor pops and compares.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst_n;

    logic       s_wr_en, s_rd_en, s_clr;
    logic [7:0] s_wr_data;
    logic       s_wr_full, s_wr_afull, s_wr_overflow;
    logic [7:0] s_rd_data;
    logic       s_rd_valid, s_rd_empty, s_rd_aempty, s_rd_underflow;
    logic [2:0] s_level;

    logic       f_wr_en, f_rd_en, f_clr;
    logic [7:0] f_wr_data;
    logic       f_wr_full, f_wr_afull, f_wr_overflow;
    logic [7:0] f_rd_data;
    logic       f_rd_valid, f_rd_empty, f_rd_aempty, f_rd_underflow;
    logic [2:0] f_level;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] q_std[$];
    logic [7:0] q_fwft[$];

    sync_fifo_flags #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
    ) u_std (
        .clk(clk), .rst_n(rst_n),
        .wr_en(s_wr_en), .wr_data(s_wr_data), .wr_full(s_wr_full), .wr_afull(s_wr_afull),
        .wr_overflow(s_wr_overflow), .rd_en(s_rd_en), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .rd_empty(s_rd_empty), .rd_aempty(s_rd_aempty),
        .rd_underflow(s_rd_underflow), .clr_err(s_clr), .level(s_level)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .wr_full(f_wr_full), .wr_afull(f_wr_afull),
        .wr_overflow(f_wr_overflow), .rd_en(f_rd_en), .rd_data(f_rd_data),
        .rd_valid(f_rd_valid), .rd_empty(f_rd_empty), .rd_aempty(f_rd_aempty),
        .rd_underflow(f_rd_underflow), .clr_err(f_clr), .level(f_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_wr(input logic [7:0] d, input bit acc);
        s_wr_en = 1'b1; s_wr_data = d;
        if (acc) q_std.push_back(d);
        tick();
        s_wr_en = 1'b0;
    endtask

    task automatic s_rd();
        s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
    endtask

    task automatic f_wr(input logic [7:0] d);
        f_wr_en = 1'b1; f_wr_data = d;
        q_fwft.push_back(d);
        tick();
        f_wr_en = 1'b0;
    endtask

    // Monitor: std pops on every rd_valid pulse, FWFT pops on every rd_valid & rd_en handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_rd_valid) begin
                if (q_std.size() == 0) begin
                    n_total++;
                    $display("FAIL std_unexpected_valid got rd_data=%0h exp no word", s_rd_data);
                end else begin
                    chk("std_rd_data", 32'(s_rd_data), 32'(q_std.pop_front()));
                end
            end
            if (f_rd_valid && f_rd_en) begin
                if (q_fwft.size() == 0) begin
                    n_total++;
                    $display("FAIL fwft_unexpected_word got rd_data=%0h exp no word", f_rd_data);
                end else begin
                    chk("fwft_rd_data", 32'(f_rd_data), 32'(q_fwft.pop_front()));
                end
            end
        end
    end

    initial begin
        int d;
        int n;
        rst_n = 1'b0;
        s_wr_en = 1'b0; s_rd_en = 1'b0; s_clr = 1'b0; s_wr_data = 8'h00;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr = 1'b0; f_wr_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level",     32'(s_level),        32'd0);
        chk("rst_empty",     32'(s_rd_empty),     32'd1);
        chk("rst_full",      32'(s_wr_full),      32'd0);
        chk("rst_afull",     32'(s_wr_afull),     32'd0);
        chk("rst_aempty",    32'(s_rd_aempty),    32'd1);
        chk("rst_valid",     32'(s_rd_valid),     32'd0);
        chk("rst_data",      32'(s_rd_data),      32'd0);
        chk("rst_ovf",       32'(s_wr_overflow),  32'd0);
        chk("rst_unf",       32'(s_rd_underflow), 32'd0);
        chk("rst_f_empty",   32'(f_rd_empty),     32'd1);
        rst_n = 1'b1;
        tick();

        // Std fill to full, overflow on the fifth write, then drain.
        s_wr(8'h11, 1'b1);
        chk("t1_lvl1_aempty", 32'(s_rd_aempty), 32'd1);
        s_wr(8'h22, 1'b1);
        chk("t1_lvl2_aempty", 32'(s_rd_aempty), 32'd0);
        chk("t1_lvl2_afull",  32'(s_wr_afull),  32'd0);
        s_wr(8'h33, 1'b1);
        chk("t1_lvl3_afull",  32'(s_wr_afull),  32'd1);
        chk("t1_lvl3_full",   32'(s_wr_full),   32'd0);
        s_wr(8'h44, 1'b1);
        chk("t1_level4",      32'(s_level),     32'd4);
        chk("t1_full",        32'(s_wr_full),   32'd1);
        s_wr(8'h55, 1'b0);
        chk("t1_ovf",         32'(s_wr_overflow), 32'd1);
        chk("t1_level_kept",  32'(s_level),     32'd4);
        for (int i = 0; i < 4; i++) s_rd();
        tick();
        chk("t1_level0",      32'(s_level),     32'd0);
        chk("t1_empty",       32'(s_rd_empty),  32'd1);
        chk("t1_data_hold",   32'(s_rd_data),   32'h44);

        // Std simultaneous write/read on full and on empty.
        s_clr = 1'b1; tick(); s_clr = 1'b0;
        chk("t2_ovf_clr", 32'(s_wr_overflow), 32'd0);
        s_wr(8'h11, 1'b1); s_wr(8'h22, 1'b1); s_wr(8'h33, 1'b1); s_wr(8'h44, 1'b1);
        s_wr_en = 1'b1; s_wr_data = 8'h55; s_rd_en = 1'b1;
        tick();
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        chk("t2_full_both_level", 32'(s_level),       32'd3);
        chk("t2_full_both_ovf",   32'(s_wr_overflow), 32'd1);
        for (int i = 0; i < 3; i++) s_rd();
        tick();
        chk("t2_drained", 32'(s_level), 32'd0);
        s_wr_en = 1'b1; s_wr_data = 8'h66; s_rd_en = 1'b1;
        q_std.push_back(8'h66);
        tick();
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        chk("t2_empty_both_valid", 32'(s_rd_valid),     32'd0);
        chk("t2_empty_both_unf",   32'(s_rd_underflow), 32'd1);
        chk("t2_empty_both_level", 32'(s_level),        32'd1);
        s_rd();
        tick();

        // Sticky: a new underflow in the clr_err cycle wins, clr_err alone clears.
        s_clr = 1'b1; s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        chk("t5_set_wins", 32'(s_rd_underflow), 32'd1);
        tick();
        s_clr = 1'b0;
        chk("t5_cleared",  32'(s_rd_underflow), 32'd0);

        // Std wrap: 10 words in rounds of 4/4/2 so pointers wrap twice.
        d = 0;
        while (d < 10) begin
            n = ((10 - d) >= 4) ? 4 : (10 - d);
            for (int i = 0; i < n; i++) s_wr(8'(d + i), 1'b1);
            chk("t4_round_level", 32'(s_level), 32'(n));
            for (int i = 0; i < n; i++) s_rd();
            d = d + n;
        end
        tick();
        chk("t4_level0", 32'(s_level), 32'd0);

        // FWFT: bypass write, fill to five words, full-rate drain.
        f_wr(8'hA5);
        chk("t3_valid", 32'(f_rd_valid), 32'd1);
        chk("t3_data",  32'(f_rd_data),  32'hA5);
        chk("t3_level", 32'(f_level),    32'd1);
        f_wr(8'hB1); f_wr(8'hB2); f_wr(8'hB3);
        chk("t3_not_full", 32'(f_wr_full), 32'd0);
        f_wr(8'hB4);
        chk("t3_full",       32'(f_wr_full),  32'd1);
        chk("t3_level5",     32'(f_level),    32'd5);
        chk("t3_data_stable", 32'(f_rd_data), 32'hA5);
        f_rd_en = 1'b1;
        repeat (5) tick();
        f_rd_en = 1'b0;
        chk("t3_empty",  32'(f_rd_empty), 32'd1);
        chk("t3_level0", 32'(f_level),    32'd0);

        // FWFT streaming: write and read in the same cycles through the bypass path.
        f_wr(8'hC0);
        f_rd_en = 1'b1;
        for (int i = 1; i < 6; i++) begin
            f_wr(8'(8'hC0 + i));
            chk("t3_stream_level", 32'(f_level), 32'd1);
        end
        tick();
        f_rd_en = 1'b0;
        chk("t3_stream_empty", 32'(f_rd_empty), 32'd1);

        // Reset mid-fill discards contents.
        s_wr(8'hA1, 1'b0); s_wr(8'hA2, 1'b0); s_wr(8'hA3, 1'b0);
        chk("t6_level3", 32'(s_level), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_level", 32'(s_level),    32'd0);
        chk("t6_rst_empty", 32'(s_rd_empty), 32'd1);
        chk("t6_rst_data",  32'(s_rd_data),  32'd0);
        chk("t6_rst_aempty", 32'(s_rd_aempty), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        s_wr(8'h77, 1'b1);
        s_rd();
        tick();

        chk("std_q_drained",  32'(q_std.size()),  32'd0);
        chk("fwft_q_drained", 32'(q_fwft.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
